uart_tx_fifo_ctrl: RTL and testbench
====================================

Name: uart_tx_fifo_ctrl

Overview:
Byte buffer and sequencer that sits directly upstream of the UART transmit control stage. It accepts bytes from the system side into a small circular FIFO and presents them one at a time on Tx_En_Sig/Tx_Data. It holds each byte stable until the transmitter returns its one-cycle Tx_Done_Sig pulse. It frees the producer from waiting out each 10-bit frame.

Parameters:
DEPTH_LOG2  4  log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 = 16 entries
DATA_W  8  byte width; the transmitter is fixed at 8, so this is not to be overridden

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
Wr_En_Sig  input  1  write strobe; one byte per cycle while high
Wr_Data  input  DATA_W  byte to enqueue, sampled when Wr_En_Sig=1
Full_Sig  output  1  FIFO holds DEPTH bytes
Empty_Sig  output  1  FIFO holds 0 bytes
Count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
Overflow_Sig  output  1  sticky; a write was attempted while full
Busy_Sig  output  1  a byte is being handed to the transmitter (state SEND)
Tx_En_Sig  output  1  enable to the transmit control stage
Tx_Data  output  DATA_W  byte under transmission; stable while Tx_En_Sig=1
Tx_Done_Sig  input  1  one-cycle completion pulse from the transmit control stage

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, Count=0.
  - Full_Sig=0, Empty_Sig=1, Overflow_Sig=0, Busy_Sig=0, Tx_En_Sig=0, Tx_Data=0, state=IDLE.
  - FIFO storage is not cleared.
  - Reset mid-frame drops Tx_En_Sig at that edge and discards all queued bytes.
- Storage: DEPTH x DATA_W register array. Pointers are DEPTH_LOG2 bits and wrap naturally (15+1 -> 0).
- Write:
  - Accepted when Wr_En_Sig=1 and Count<DEPTH at that cycle. mem[wr_ptr]<=Wr_Data and wr_ptr++.
  - Full is judged before any same-cycle pop: a write while full is dropped even if a pop occurs in the same cycle.
- Dropped write: Overflow_Sig<=1 and stays set until reset. Count and pointers are unchanged.
- Pop: occurs only in IDLE with Count!=0. Tx_Data<=mem[rd_ptr] and rd_ptr++.
- Count: +1 on accepted write only; -1 on pop only; unchanged when both or neither occur.
- Flags: Full_Sig=(Count==DEPTH) and Empty_Sig=(Count==0), derived from registered Count.
- A write into an empty FIFO is not popped in the same cycle. The earliest pop is the next cycle.
- State machine:
  - IDLE: Tx_En_Sig=0. If Count!=0: pop, Tx_En_Sig<=1, Busy_Sig<=1, go SEND. Else stay.
  - SEND: Tx_En_Sig=1 and Tx_Data held. On Tx_Done_Sig=1: Tx_En_Sig<=0, Busy_Sig<=0, go IDLE. Else stay.
- Tx_Done_Sig is ignored in IDLE.
- Inter-frame gap: Tx_En_Sig is low for exactly one cycle between back-to-back bytes. Done seen in cycle D gives En low at D+1 and En high with the new Tx_Data at D+2. This guarantees the transmitter returns to its start state before the next frame.
- Latency: write at edge N, Tx_En_Sig rises at edge N+2 when idle and empty.
- Tx_Data changes only on a pop. It is never modified while Tx_En_Sig=1.
- Byte order is strict FIFO.

Test Plan:
- Reset, then write 0x55 alone -> Count=1 at N+1; Tx_En_Sig=1 with Tx_Data=0x55 at N+2; Count=0, Empty_Sig=1; after Done pulse Tx_En_Sig=0 and Busy_Sig=0.
- Burst-write 0x01..0x05 on consecutive cycles, model Done every 100 cycles -> Tx_Data sequence 0x01..0x05 in order; Tx_En_Sig low exactly 1 cycle between bytes; Tx_Data stable while En high.
- Write 17 bytes with no Done -> first byte popped into SEND; Count reaches 16 at byte 17, Full_Sig=1, Overflow_Sig=0; write an 18th byte -> dropped, Overflow_Sig=1 sticky, Count stays 16.
- Full FIFO plus simultaneous Wr_En_Sig and pop -> write dropped, Overflow_Sig=1, Count 16->15; pointer wrap past entry 15 preserves order across 20+ bytes.
- Stray Tx_Done_Sig pulse while IDLE and empty -> no state change, Count=0, Tx_En_Sig=0.
- Assert RST mid-SEND with 3 bytes queued -> next edge Tx_En_Sig=0, Tx_Data=0, Count=0, Empty_Sig=1; new write 0xA5 is transmitted next, not the old bytes.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl.sv
// Circular byte FIFO feeding the UART transmit control stage; presents one byte
// at a time on Tx_En_Sig/Tx_Data and waits for the Tx_Done_Sig pulse before the next.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Wr_En_Sig,
  input  logic [DATA_W-1:0]     Wr_Data,
  output logic                  Full_Sig,
  output logic                  Empty_Sig,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow_Sig,
  output logic                  Busy_Sig,
  output logic                  Tx_En_Sig,
  output logic [DATA_W-1:0]     Tx_Data,
  input  logic                  Tx_Done_Sig
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_en_q, tx_en_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  state_t                state_q, state_d;

  logic full, wr_accept, wr_drop, pop;

  // Fullness comes from the registered count, so a same-cycle pop never rescues a write.
  assign full      = (count_q == DEPTH_CNT);
  assign wr_accept = Wr_En_Sig && !full;
  assign wr_drop   = Wr_En_Sig && full;

  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
    rd_ptr_d  = rd_ptr_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          tx_en_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (Tx_Done_Sig) begin
          tx_en_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    overflow_d = overflow_q | wr_drop;
    count_d    = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left out of reset so it maps onto plain register/RAM cells.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= Wr_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign Full_Sig     = full;
  assign Empty_Sig    = (count_q == '0);
  assign Count        = count_q;
  assign Overflow_Sig = overflow_q;
  assign Busy_Sig     = busy_q;
  assign Tx_En_Sig    = tx_en_q;
  assign Tx_Data      = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: single byte, burst ordering and gap,
// full/overflow, full-with-pop, pointer wrap, stray done, and mid-frame reset.
module tb_uart_tx_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Wr_En_Sig;
  logic [7:0] Wr_Data;
  logic       Full_Sig, Empty_Sig, Overflow_Sig, Busy_Sig, Tx_En_Sig;
  logic [4:0] Count;
  logic [7:0] Tx_Data;
  logic       Tx_Done_Sig;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       stable;

  uart_tx_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .Wr_En_Sig(Wr_En_Sig), .Wr_Data(Wr_Data),
    .Full_Sig(Full_Sig), .Empty_Sig(Empty_Sig), .Count(Count),
    .Overflow_Sig(Overflow_Sig), .Busy_Sig(Busy_Sig), .Tx_En_Sig(Tx_En_Sig),
    .Tx_Data(Tx_Data), .Tx_Done_Sig(Tx_Done_Sig)
  );

  always #5 CLK = ~CLK;

  // Inputs are changed and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    Wr_En_Sig = 1'b1;
    Wr_Data   = b;
    tick();
    Wr_En_Sig = 1'b0;
  endtask

  task automatic done_pulse();
    Tx_Done_Sig = 1'b1;
    tick();
    Tx_Done_Sig = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    for (int c = 0; c < 8 && Tx_En_Sig !== 1'b1; c++) tick();
    chk(tag, Tx_En_Sig, 1);
  endtask

  initial begin
    RST = 1'b1; Wr_En_Sig = 1'b0; Wr_Data = 8'h00; Tx_Done_Sig = 1'b0;
    #1;
    tick(); tick();
    RST = 1'b0;
    chk("rst_count", Count, 0);
    chk("rst_empty", Empty_Sig, 1);
    chk("rst_full", Full_Sig, 0);
    chk("rst_ovf", Overflow_Sig, 0);
    chk("rst_busy", Busy_Sig, 0);
    chk("rst_en", Tx_En_Sig, 0);
    chk("rst_data", Tx_Data, 0);

    // Single byte: count after write edge, enable one edge later.
    wr(8'h55);
    chk("one_count1", Count, 1);
    chk("one_en_early", Tx_En_Sig, 0);
    tick();
    chk("one_en", Tx_En_Sig, 1);
    chk("one_data", Tx_Data, 8'h55);
    chk("one_count0", Count, 0);
    chk("one_empty", Empty_Sig, 1);
    chk("one_busy", Busy_Sig, 1);
    done_pulse();
    chk("one_en_off", Tx_En_Sig, 0);
    chk("one_busy_off", Busy_Sig, 0);

    // Burst 1..5, done every 100 cycles.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("burst_count", Count, 4);
    chk("burst_first", Tx_Data, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      chk("burst_en", Tx_En_Sig, 1);
      chk("burst_data", Tx_Data, k);
      stable = 1'b1;
      for (int c = 0; c < 99; c++) begin
        tick();
        if (Tx_Data !== 8'(k) || Tx_En_Sig !== 1'b1) stable = 1'b0;
      end
      chk("burst_stable", stable, 1);
      done_pulse();
      chk("burst_gap", Tx_En_Sig, 0);
      if (k < 5) tick();
    end
    chk("burst_empty", Empty_Sig, 1);

    // 17 writes, no done: first byte goes out, remaining 16 fill the FIFO.
    for (int i = 0; i < 17; i++) wr(8'(8'h10 + i));
    chk("fill_count", Count, 16);
    chk("fill_full", Full_Sig, 1);
    chk("fill_ovf0", Overflow_Sig, 0);
    chk("fill_data", Tx_Data, 8'h10);
    wr(8'h77);
    chk("drop_count", Count, 16);
    chk("drop_ovf", Overflow_Sig, 1);
    chk("drop_data", Tx_Data, 8'h10);

    // Back to IDLE while full, then write coincident with the pop.
    done_pulse();
    chk("fp_idle_en", Tx_En_Sig, 0);
    chk("fp_idle_cnt", Count, 16);
    wr(8'h99);
    chk("fp_count", Count, 15);
    chk("fp_ovf", Overflow_Sig, 1);
    chk("fp_full", Full_Sig, 0);
    chk("fp_en", Tx_En_Sig, 1);

    // Drain with wrap: 0x11..0x20 queued, 0x21..0x25 written on done cycles.
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h11 + i));
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_en("wrap_en");
      exp_b = exp_q.pop_front();
      chk("wrap_data", Tx_Data, exp_b);
      Tx_Done_Sig = 1'b1;
      if (i < 5) begin
        Wr_En_Sig = 1'b1;
        Wr_Data   = 8'(8'h21 + i);
        exp_q.push_back(8'(8'h21 + i));
      end
      tick();
      Tx_Done_Sig = 1'b0;
      Wr_En_Sig   = 1'b0;
    end
    chk("wrap_en_off", Tx_En_Sig, 0);
    chk("wrap_empty", Empty_Sig, 1);
    chk("wrap_ovf_sticky", Overflow_Sig, 1);

    // Stray done while idle and empty.
    tick();
    done_pulse();
    chk("stray_en", Tx_En_Sig, 0);
    chk("stray_count", Count, 0);
    chk("stray_busy", Busy_Sig, 0);
    tick();
    chk("stray_en2", Tx_En_Sig, 0);

    // Reset mid-frame with three queued bytes.
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    chk("mr_count", Count, 3);
    chk("mr_en", Tx_En_Sig, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mr_en_off", Tx_En_Sig, 0);
    chk("mr_data", Tx_Data, 0);
    chk("mr_count0", Count, 0);
    chk("mr_empty", Empty_Sig, 1);
    chk("mr_ovf", Overflow_Sig, 0);
    chk("mr_busy", Busy_Sig, 0);
    tick();
    chk("mr_idle", Tx_En_Sig, 0);
    wr(8'hA5);
    tick();
    chk("mr_new_en", Tx_En_Sig, 1);
    chk("mr_new_data", Tx_Data, 8'hA5);
    chk("mr_new_empty", Empty_Sig, 1);
    tick();
    chk("mr_hold", Tx_Data, 8'hA5);
    done_pulse();
    tick();
    chk("mr_end_en", Tx_En_Sig, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
